// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. Lookup is purely combinational so fetch never stalls; updates
//   from execute commit on the next rising edge with no bypass into lookup.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   lookup_pc          fetch PC being predicted
//   hit                lookup_pc matches a valid entry
//   predict_taken      hit and counter in a taken state
//   predict_target     stored target when predicted taken, else lookup_pc+4
//   update_en          resolved branch/jump from execute this cycle
//   update_pc          PC of the resolved instruction
//   update_taken       resolved direction
//   update_target      resolved target address
//   update_mispredict  execute flagged a wrong prediction (qualified by update_en)
//   mispredict_count   saturating count of qualified mispredicts
//   update_count       saturating count of update_en cycles
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_mispredict,
  output logic [15:0] mispredict_count,
  output logic [15:0] update_count
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]            validQ;
  logic [ENTRIES-1:0][1:0]       ctrQ;
  logic [ENTRIES-1:0][TAG_W-1:0] tagQ;
  logic [ENTRIES-1:0][31:0]      targetQ;

  logic [IDX_W-1:0] lkIdx, upIdx;
  logic [TAG_W-1:0] lkTag, upTag;
  logic             upHit;

  // Instruction alignment bits carry no information for prediction.
  logic unusedPcBits;
  assign unusedPcBits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign lkIdx = lookup_pc[IDX_W+1:2];
  assign lkTag = lookup_pc[31:IDX_W+2];
  assign upIdx = update_pc[IDX_W+1:2];
  assign upTag = update_pc[31:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not seen.
  always_comb begin
    hit            = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
    predict_taken  = hit && ctrQ[lkIdx][1];
    predict_target = predict_taken ? targetQ[lkIdx] : lookup_pc + 32'd4;
  end

  assign upHit = validQ[upIdx] && (tagQ[upIdx] == upTag);

  // Valid bits and counters are the only entry state that needs reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ <= '0;
      ctrQ   <= {ENTRIES{2'b01}};
    end else if (update_en) begin
      if (upHit) begin
        if (update_taken) begin
          if (ctrQ[upIdx] != 2'b11) ctrQ[upIdx] <= ctrQ[upIdx] + 2'd1;
        end else if (ctrQ[upIdx] != 2'b00) begin
          ctrQ[upIdx] <= ctrQ[upIdx] - 2'd1;
        end
      end else if (update_taken) begin
        validQ[upIdx] <= 1'b1;
        ctrQ[upIdx]   <= 2'b10;
      end
    end
  end

  // Tag/target written on every taken update: on a hit the tag is rewritten
  // unchanged, on a miss it is the allocation. Not-taken never writes.
  always_ff @(posedge clk) begin
    if (update_en && update_taken && !rst) begin
      tagQ[upIdx]    <= upTag;
      targetQ[upIdx] <= update_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_count <= '0;
      update_count     <= '0;
    end else if (update_en) begin
      if (update_count != 16'hFFFF) update_count <= update_count + 16'd1;
      if (update_mispredict && mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        hit, predict_taken;
  logic [31:0] predict_target;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        update_mispredict = 1'b0;
  logic [15:0] mispredict_count, update_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .hit(hit),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .mispredict_count(mispredict_count), .update_count(update_count)
  );

  // Reference model: table keyed by word address modulo ENTRIES.
  bit          mValid [ENTRIES];
  longint      mTag   [ENTRIES];
  logic [31:0] mTarget[ENTRIES];
  int          mCtr   [ENTRIES];
  int          mMisp, mUpd;

  function automatic void mReset();
    for (int i = 0; i < ENTRIES; i++) begin mValid[i] = 0; mCtr[i] = 1; end
    mMisp = 0; mUpd = 0;
  endfunction

  function automatic void mPredict(input logic [31:0] pc, output bit h,
                                   output bit pt, output logic [31:0] tgt);
    longint word = longint'(pc) / 4;
    int i = int'(word % ENTRIES);
    h   = mValid[i] && (mTag[i] == word / ENTRIES);
    pt  = h && (mCtr[i] >= 2);
    tgt = pt ? mTarget[i] : 32'((longint'(pc) + 4) % 64'h1_0000_0000);
  endfunction

  function automatic void mApply(input logic [31:0] pc, input bit tk,
                                 input logic [31:0] tgt, input bit misp);
    longint word = longint'(pc) / 4;
    int i = int'(word % ENTRIES);
    bit h = mValid[i] && (mTag[i] == word / ENTRIES);
    if (h) begin
      mCtr[i] = tk ? ((mCtr[i] < 3) ? mCtr[i] + 1 : 3) : ((mCtr[i] > 0) ? mCtr[i] - 1 : 0);
      if (tk) mTarget[i] = tgt;
    end else if (tk) begin
      mValid[i] = 1; mTag[i] = word / ENTRIES; mTarget[i] = tgt; mCtr[i] = 2;
    end
    if (mUpd < 65535) mUpd++;
    if (misp && mMisp < 65535) mMisp++;
  endfunction

  // One clock edge; the model follows whatever the DUT sees at that edge.
  task automatic tick();
    @(posedge clk);
    if (update_en && !rst) mApply(update_pc, update_taken, update_target, update_mispredict);
    #1;
  endtask

  task automatic doUpdate(input logic [31:0] pc, input bit tk,
                          input logic [31:0] tgt, input bit misp);
    update_en = 1; update_pc = pc; update_taken = tk;
    update_target = tgt; update_mispredict = misp;
    tick();
    update_en = 0; update_mispredict = 0;
  endtask

  task automatic test_reset();
    bit h, pt; logic [31:0] t;
    lookup_pc = 32'h100;
    update_en = 1; update_pc = 32'h100; update_taken = 1; update_target = 32'h200;
    update_mispredict = 1;
    #2;
    tick();  // edge while rst high: update must be discarded
    update_en = 0; update_mispredict = 0;
    rst = 0;
    #2;
    mPredict(lookup_pc, h, pt, t);
    checks++;
    if (hit !== 1'b0 || predict_taken !== 1'b0 || predict_target !== 32'h104 ||
        h || pt || t !== 32'h104) begin
      failures++;
      $display("FAIL reset_lookup got hit=%0b pt=%0b tgt=%h want 0 0 00000104",
               hit, predict_taken, predict_target);
    end
    checks++;
    if (mispredict_count !== 16'd0 || update_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters got m=%0d u=%0d want 0 0", mispredict_count, update_count);
    end
  endtask

  task automatic test_alloc();
    doUpdate(32'h100, 1, 32'h200, 0);
    lookup_pc = 32'h100; #1;
    checks++;
    if (hit !== 1 || predict_taken !== 1 || predict_target !== 32'h200) begin
      failures++;
      $display("FAIL alloc_hit got hit=%0b pt=%0b tgt=%h want 1 1 00000200",
               hit, predict_taken, predict_target);
    end
    lookup_pc = 32'h140; #1;
    checks++;
    if (hit !== 0 || predict_target !== 32'h144) begin
      failures++;
      $display("FAIL alias_miss got hit=%0b tgt=%h want 0 00000144", hit, predict_target);
    end
    checks++;
    if (update_count !== 16'd1) begin
      failures++;
      $display("FAIL update_count_one got %0d want 1", update_count);
    end
  endtask

  task automatic test_ctr();
    for (int k = 0; k < 3; k++) doUpdate(32'h100, 0, 32'h0, 1);
    lookup_pc = 32'h100; #1;
    checks++;
    if (hit !== 1 || predict_taken !== 0 || predict_target !== 32'h104) begin
      failures++;
      $display("FAIL ctr_down got hit=%0b pt=%0b tgt=%h want 1 0 00000104",
               hit, predict_taken, predict_target);
    end
    doUpdate(32'h100, 1, 32'h280, 0);  // 00 -> 01, still not taken
    #1;
    checks++;
    if (hit !== 1 || predict_taken !== 0) begin
      failures++;
      $display("FAIL ctr_floor got hit=%0b pt=%0b want 1 0", hit, predict_taken);
    end
    doUpdate(32'h100, 1, 32'h2C0, 0);  // 01 -> 10, taken to latest target
    #1;
    checks++;
    if (predict_taken !== 1 || predict_target !== 32'h2C0) begin
      failures++;
      $display("FAIL ctr_up got pt=%0b tgt=%h want 1 000002c0", predict_taken, predict_target);
    end
    checks++;
    if (mispredict_count !== 16'd3 || update_count !== 16'd6) begin
      failures++;
      $display("FAIL counters_mid got m=%0d u=%0d want 3 6", mispredict_count, update_count);
    end
  endtask

  task automatic test_same_edge();
    rst = 1; #1; rst = 0; mReset(); #1;
    lookup_pc = 32'h100;
    update_en = 1; update_pc = 32'h100; update_taken = 1; update_target = 32'h300;
    #1;
    checks++;
    if (hit !== 0 || predict_target !== 32'h104) begin
      failures++;
      $display("FAIL same_edge_before got hit=%0b tgt=%h want 0 00000104", hit, predict_target);
    end
    tick();
    update_en = 0; #1;
    checks++;
    if (hit !== 1 || predict_taken !== 1 || predict_target !== 32'h300) begin
      failures++;
      $display("FAIL same_edge_after got hit=%0b pt=%0b tgt=%h want 1 1 00000300",
               hit, predict_taken, predict_target);
    end
  endtask

  task automatic test_miss_nottaken_wrap();
    doUpdate(32'h180, 0, 32'h900, 0);
    lookup_pc = 32'h180; #1;
    checks++;
    if (hit !== 0 || predict_target !== 32'h184) begin
      failures++;
      $display("FAIL no_alloc got hit=%0b tgt=%h want 0 00000184", hit, predict_target);
    end
    lookup_pc = 32'hFFFF_FFFC; #1;
    checks++;
    if (hit !== 0 || predict_target !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap got hit=%0b tgt=%h want 0 00000000", hit, predict_target);
    end
  endtask

  function automatic logic [31:0] randPc();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'(($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, ENTRIES - 1) << 2)
               | $urandom_range(0, 3));
  endfunction

  task automatic test_random();
    bit h, pt; logic [31:0] t;
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      lookup_pc = randPc();
      update_en = ($urandom_range(0, 3) != 0);
      update_pc = randPc();
      update_taken = $urandom_range(0, 1);
      update_target = $urandom;
      update_mispredict = $urandom_range(0, 1);
      #1;
      mPredict(lookup_pc, h, pt, t);
      if (hit !== h || predict_taken !== pt || predict_target !== t) begin
        bad++;
        if (bad < 5)
          $display("FAIL random_lookup pc=%h got %0b %0b %h want %0b %0b %h",
                   lookup_pc, hit, predict_taken, predict_target, h, pt, t);
      end
      tick();
    end
    update_en = 0; update_mispredict = 0; #1;
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (update_count !== 16'(mUpd) || mispredict_count !== 16'(mMisp)) begin
      failures++;
      $display("FAIL random_counters got m=%0d u=%0d want %0d %0d",
               mispredict_count, update_count, mMisp, mUpd);
    end
  endtask

  task automatic test_saturation_async_reset();
    bit anyHit = 0;
    update_en = 1; update_pc = 32'h100; update_taken = 1; update_target = 32'h200;
    update_mispredict = 1;
    for (int n = 0; n < 65600; n++) tick();
    checks++;
    if (update_count !== 16'hFFFF || mispredict_count !== 16'hFFFF || mUpd != 65535) begin
      failures++;
      $display("FAIL saturate got m=%h u=%h want ffff ffff", mispredict_count, update_count);
    end
    lookup_pc = 32'h100; #1;
    checks++;
    if (hit !== 1) begin
      failures++;
      $display("FAIL pre_reset_hit got %0b want 1", hit);
    end
    // Mid-cycle async reset with update_en still high.
    #1; rst = 1; #1; mReset();
    checks++;
    if (update_count !== 16'd0 || mispredict_count !== 16'd0) begin
      failures++;
      $display("FAIL async_reset_counters got m=%0d u=%0d want 0 0",
               mispredict_count, update_count);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      lookup_pc = 32'h100 + 32'(i * 4); #0.1;
      if (hit !== 0) anyHit = 1;
    end
    checks++;
    if (anyHit) begin
      failures++;
      $display("FAIL async_reset_lookup got a hit want none");
    end
    tick();
    update_en = 0; update_mispredict = 0; rst = 0; #1;
    checks++;
    if (update_count !== 16'd0 || hit !== 0) begin
      failures++;
      $display("FAIL reset_discard got u=%0d hit=%0b want 0 0", update_count, hit);
    end
  endtask

  initial begin
    mReset();
    test_reset();
    test_alloc();
    test_ctr();
    test_same_edge();
    test_miss_nottaken_wrap();
    test_random();
    test_saturation_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
